// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, widths and coin decode for the vending sequencer
package vend_pkg;
  localparam int CREDIT_W = 8;

  typedef enum logic [1:0] {
    C25  = 2'd0,
    C50  = 2'd1,
    C100 = 2'd2,
    CBAD = 2'd3
  } coin_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CREDIT   = 3'd1,
    S_DISPENSE = 3'd2,
    S_RELEASE  = 3'd3,
    S_CHANGE   = 3'd4
  } state_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input coin_t c);
    case (c)
      C25:     return 8'd25;
      C50:     return 8'd50;
      C100:    return 8'd100;
      default: return 8'd0;
    endcase
  endfunction
endpackage

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin decode, ceiling check and credit register
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int PRICE      = 150,
  parameter int MAX_CREDIT = 250
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_coin_valid,
  input  logic [1:0]          i_coin_type,
  input  logic                i_coin_block,
  input  logic                i_sub_price,
  input  logic                i_clear,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_coin_accept,
  output logic                o_reject
);
  coin_t               ctype;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] credit_d, credit_q;
  logic                reject_d, reject_q;

  assign ctype = coin_t'(i_coin_type);
  // One extra bit so an overflowing coin is caught before it wraps.
  assign sum   = {1'b0, credit_q} + {1'b0, coin_value(ctype)};
  assign o_coin_accept = i_coin_valid && !i_coin_block && (ctype != CBAD) &&
                         (sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    credit_d = credit_q;
    if (i_clear)            credit_d = '0;
    else if (i_sub_price)   credit_d = credit_q - CREDIT_W'(PRICE);
    else if (o_coin_accept) credit_d = sum[CREDIT_W-1:0];
    reject_d = i_coin_valid && !o_coin_accept;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign o_credit = credit_q;
  assign o_reject = reject_q;
endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - sale sequencer driving the dispense timer start/value handshake
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int          PRICE          = 150,
  parameter int          MAX_CREDIT     = 250,
  parameter logic [31:0] DISPENSE_TICKS = 32'd50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_coin_valid,
  input  logic [1:0]  i_coin_type,
  input  logic        i_select_valid,
  input  logic [1:0]  i_select,
  input  logic        i_cancel,
  input  logic [3:0]  i_stock,
  input  logic        i_timer_done,
  output logic        o_timer_start,
  output logic [31:0] o_timer_value,
  output logic [3:0]  o_valve,
  output logic [7:0]  o_credit,
  output logic        o_coin_reject,
  output logic        o_sel_reject,
  output logic        o_change_valid,
  output logic [7:0]  o_change_cents,
  output logic        o_busy
);
  state_t              state_d, state_q;
  logic [1:0]          sel_d, sel_q;
  logic [3:0]          valve_d, valve_q;
  logic                start_d, start_q;
  logic                sel_rej_d, sel_rej_q;
  logic                chg_valid_d, chg_valid_q;
  logic [7:0]          chg_cents_d, chg_cents_q;
  logic                busy_d, busy_q;
  logic                idle_like, cancel_hit;
  logic                coin_block, coin_accept, sub_price, clear;
  logic [CREDIT_W-1:0] credit;

  assign idle_like  = (state_q == S_IDLE) || (state_q == S_CREDIT);
  assign cancel_hit = i_cancel && (credit != '0);
  // A coin arriving alongside an effective cancel or any selection loses priority.
  assign coin_block = !idle_like || cancel_hit || i_select_valid;

  coin_acceptor #(
    .PRICE      (PRICE),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_coin (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_coin_valid  (i_coin_valid),
    .i_coin_type   (i_coin_type),
    .i_coin_block  (coin_block),
    .i_sub_price   (sub_price),
    .i_clear       (clear),
    .o_credit      (credit),
    .o_coin_accept (coin_accept),
    .o_reject      (o_coin_reject)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    valve_d     = valve_q;
    start_d     = start_q;
    sel_rej_d   = 1'b0;
    chg_valid_d = 1'b0;
    chg_cents_d = '0;
    sub_price   = 1'b0;
    clear       = 1'b0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel_hit) begin
          chg_valid_d = 1'b1;
          chg_cents_d = credit;
          clear       = 1'b1;
          state_d     = S_IDLE;
        end else if (i_select_valid) begin
          if (credit >= CREDIT_W'(PRICE) && i_stock[i_select]) begin
            sel_d   = i_select;
            valve_d = 4'(4'b0001 << i_select);
            start_d = 1'b1;
            state_d = S_DISPENSE;
          end else begin
            sel_rej_d = 1'b1;
          end
        end else begin
          state_d = (coin_accept || credit != '0) ? S_CREDIT : S_IDLE;
        end
      end
      S_DISPENSE: begin
        valve_d = 4'(4'b0001 << sel_q);
        start_d = 1'b1;
        if (i_timer_done) begin
          valve_d   = '0;
          start_d   = 1'b0;
          sub_price = 1'b1;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Start stays low until the timer is seen back in its wait state.
        if (!i_timer_done) begin
          if (credit != '0) begin
            chg_valid_d = 1'b1;
            chg_cents_d = credit;
            state_d     = S_CHANGE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        clear   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DISPENSE) || (state_d == S_RELEASE) || (state_d == S_CHANGE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      valve_q     <= '0;
      start_q     <= 1'b0;
      sel_rej_q   <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_cents_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      valve_q     <= valve_d;
      start_q     <= start_d;
      sel_rej_q   <= sel_rej_d;
      chg_valid_q <= chg_valid_d;
      chg_cents_q <= chg_cents_d;
      busy_q      <= busy_d;
    end
  end

  assign o_timer_start  = start_q;
  assign o_timer_value  = DISPENSE_TICKS;
  assign o_valve        = valve_q;
  assign o_credit       = credit;
  assign o_sel_reject   = sel_rej_q;
  assign o_change_valid = chg_valid_q;
  assign o_change_cents = chg_cents_q;
  assign o_busy         = busy_q;
endmodule
